vending_machine_upi_top: RTL and testbench



---
 rtl/vending_machine_upi_top.sv | 149 ++++++++++++++
 tb/tb_vending_machine_upi_top.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_upi_top.sv
// Vending-machine controller with an integrated UPI payment model.
// Quotes a price in IDLE, runs a timed payment, drives the spring motor and pulses dispense.
module vending_machine_upi_top #(
  parameter int PAY_LATENCY  = 8,
  parameter int PAY_TIMEOUT  = 64,
  parameter int MOTOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tray_sel,
  input  logic [2:0] product_sel,
  input  logic       upi_pay_req,
  output logic       spring_motor_en,
  output logic       dispense,
  output logic [7:0] amount,
  output logic       error,
  output logic       upi_pay_done,
  output logic       upi_busy,
  output logic       upi_success
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PAY = 2'd1,
    VEND     = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0] LAT_LAST   = 8'(PAY_LATENCY - 1);
  localparam logic [7:0] TO_LAST    = 8'(PAY_TIMEOUT - 1);
  localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] r_motor_cnt;
  logic [7:0] r_pay_cnt;
  logic [7:0] r_amount;
  logic       r_error;
  logic       r_pay_done;
  logic       r_busy;
  logic       r_success;

  logic       w_valid;
  logic [7:0] w_price;
  logic       w_start;
  logic       w_timeout;

  assign w_valid   = (tray_sel <= 3'd4) && (product_sel <= 3'd4);
  assign w_price   = 8'd10 * ({5'd0, tray_sel} + 8'd1) + 8'd5 * {5'd0, product_sel};
  assign w_start   = (r_state == IDLE) && upi_pay_req && w_valid;
  // A completion pulse already on the wire wins over a timeout landing on the same cycle.
  assign w_timeout = (r_state == WAIT_PAY) && (r_wait_cnt == TO_LAST) && !r_pay_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_start) w_next_state = WAIT_PAY;
      WAIT_PAY: begin
        if (r_pay_done)     w_next_state = VEND;
        else if (w_timeout) w_next_state = IDLE;
      end
      VEND:     if (r_motor_cnt == MOTOR_LAST) w_next_state = DONE;
      DONE:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    spring_motor_en = 1'b0;
    dispense        = 1'b0;
    case (r_state)
      VEND:    spring_motor_en = 1'b1;
      DONE:    dispense        = 1'b1;
      default: ;
    endcase
  end

  // Per-state cycle counters; each reads k-1 at the k-th edge spent in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= 8'd0;
      r_motor_cnt <= 8'd0;
    end else begin
      r_wait_cnt  <= (r_state == WAIT_PAY) ? r_wait_cnt + 8'd1 : 8'd0;
      r_motor_cnt <= (r_state == VEND)     ? r_motor_cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_amount <= 8'd0;
      r_error  <= 1'b0;
    end else if (r_state == IDLE) begin
      r_amount <= w_valid ? w_price : 8'd0;
      r_error  <= !w_valid;
    end else begin
      r_error  <= w_timeout;
    end
  end

  // Payment model: counts PAY_LATENCY cycles from start, aborted by the FSM on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pay_cnt  <= 8'd0;
      r_pay_done <= 1'b0;
      r_busy     <= 1'b0;
      r_success  <= 1'b0;
    end else if (w_start) begin
      r_pay_cnt  <= 8'd0;
      r_pay_done <= 1'b0;
      r_busy     <= 1'b1;
      r_success  <= 1'b0;
    end else if (w_timeout) begin
      r_pay_cnt  <= 8'd0;
      r_pay_done <= 1'b0;
      r_busy     <= 1'b0;
    end else if (r_busy) begin
      if (r_pay_cnt == LAT_LAST) begin
        r_pay_cnt  <= 8'd0;
        r_pay_done <= 1'b1;
        r_busy     <= 1'b0;
        r_success  <= 1'b1;
      end else begin
        r_pay_cnt  <= r_pay_cnt + 8'd1;
        r_pay_done <= 1'b0;
      end
    end else begin
      r_pay_done <= 1'b0;
    end
  end

  assign amount       = r_amount;
  assign error        = r_error;
  assign upi_pay_done = r_pay_done;
  assign upi_busy     = r_busy;
  assign upi_success  = r_success;

endmodule

// File: tb/tb_vending_machine_upi_top.sv
// Directed bench for vending_machine_upi_top: default instance plus a short-timeout instance.
module tb_vending_machine_upi_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tray_sel;
  logic [2:0] product_sel;
  logic       upi_pay_req;
  logic       upi_pay_req_2;

  logic       spring_motor_en, dispense, error, upi_pay_done, upi_busy, upi_success;
  logic [7:0] amount;
  logic       spring_motor_en_2, dispense_2, error_2, upi_pay_done_2, upi_busy_2, upi_success_2;
  logic [7:0] amount_2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vending_machine_upi_top dut (
    .clk(clk), .rst(rst), .tray_sel(tray_sel), .product_sel(product_sel),
    .upi_pay_req(upi_pay_req), .spring_motor_en(spring_motor_en), .dispense(dispense),
    .amount(amount), .error(error), .upi_pay_done(upi_pay_done), .upi_busy(upi_busy),
    .upi_success(upi_success)
  );

  vending_machine_upi_top #(.PAY_LATENCY(20), .PAY_TIMEOUT(10), .MOTOR_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .tray_sel(tray_sel), .product_sel(product_sel),
    .upi_pay_req(upi_pay_req_2), .spring_motor_en(spring_motor_en_2), .dispense(dispense_2),
    .amount(amount_2), .error(error_2), .upi_pay_done(upi_pay_done_2), .upi_busy(upi_busy_2),
    .upi_success(upi_success_2)
  );

  // Advance one rising edge and settle; inputs driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dispense(input string name);
    int n;
    n = 0;
    while (dispense !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (dispense !== 1'b1) begin
      fails++;
      $display("FAIL %s: dispense never seen within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tray_sel = 3'd7; product_sel = 3'd7; upi_pay_req = 1'b1; upi_pay_req_2 = 1'b1;
    step();
    step();
    tests++;
    if ({spring_motor_en, dispense, amount, error, upi_pay_done, upi_busy, upi_success} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs: got motor=%b disp=%b amt=%0d err=%b done=%b busy=%b succ=%b, want all 0",
               spring_motor_en, dispense, amount, error, upi_pay_done, upi_busy, upi_success);
    end
    tests++;
    if ({spring_motor_en_2, dispense_2, amount_2, error_2, upi_pay_done_2, upi_busy_2, upi_success_2} !== 14'd0) begin
      fails++;
      $display("FAIL reset_outputs_2: some output nonzero, want all 0");
    end
    rst = 1'b0; upi_pay_req = 1'b0; upi_pay_req_2 = 1'b0; tray_sel = 3'd0; product_sel = 3'd0;
    step();
  endtask

  task automatic test_price();
    logic [2:0] t_tab [5] = '{3'd0, 3'd4, 3'd2, 3'd4, 3'd5};
    logic [2:0] p_tab [5] = '{3'd0, 3'd4, 3'd3, 3'd5, 3'd0};
    logic [7:0] a_tab [5] = '{8'd10, 8'd70, 8'd45, 8'd0, 8'd0};
    logic       e_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tray_sel = t_tab[i]; product_sel = p_tab[i];
      step();
      tests++;
      if (amount !== a_tab[i] || error !== e_tab[i]) begin
        fails++;
        $display("FAIL price[%0d]: got amount=%0d error=%b, want amount=%0d error=%b",
                 i, amount, error, a_tab[i], e_tab[i]);
      end
    end
  endtask

  task automatic test_vend();
    tray_sel = 3'd1; product_sel = 3'd2;
    step();
    upi_pay_req = 1'b1;
    step();  // E0
    upi_pay_req = 1'b0;
    tests++;
    if (upi_busy !== 1'b1 || amount !== 8'd30 || upi_success !== 1'b0) begin
      fails++;
      $display("FAIL vend_accept: got busy=%b amount=%0d succ=%b, want 1/30/0", upi_busy, amount, upi_success);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      tests++;
      if (upi_busy !== 1'b1 || upi_pay_done !== 1'b0) begin
        fails++;
        $display("FAIL vend_busy[%0d]: got busy=%b done=%b, want 1/0", k, upi_busy, upi_pay_done);
      end
    end
    step();  // E0+8
    tests++;
    if (upi_pay_done !== 1'b1 || upi_success !== 1'b1 || upi_busy !== 1'b0 || spring_motor_en !== 1'b0) begin
      fails++;
      $display("FAIL vend_paydone: got done=%b succ=%b busy=%b motor=%b, want 1/1/0/0",
               upi_pay_done, upi_success, upi_busy, spring_motor_en);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if (spring_motor_en !== 1'b1 || dispense !== 1'b0 || upi_pay_done !== 1'b0) begin
        fails++;
        $display("FAIL vend_motor[%0d]: got motor=%b disp=%b done=%b, want 1/0/0",
                 k, spring_motor_en, dispense, upi_pay_done);
      end
    end
    step();  // E0+13
    tests++;
    if (dispense !== 1'b1 || spring_motor_en !== 1'b0 || amount !== 8'd30) begin
      fails++;
      $display("FAIL vend_dispense: got disp=%b motor=%b amount=%0d, want 1/0/30", dispense, spring_motor_en, amount);
    end
    step();
    tests++;
    if (dispense !== 1'b0 || spring_motor_en !== 1'b0 || upi_success !== 1'b1) begin
      fails++;
      $display("FAIL vend_after: got disp=%b motor=%b succ=%b, want 0/0/1", dispense, spring_motor_en, upi_success);
    end
  endtask

  task automatic test_invalid();
    tray_sel = 3'd6; product_sel = 3'd1;
    step();
    tests++;
    if (error !== 1'b1 || amount !== 8'd0) begin
      fails++;
      $display("FAIL invalid_quote: got error=%b amount=%0d, want 1/0", error, amount);
    end
    upi_pay_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if (upi_busy !== 1'b0 || error !== 1'b1 || spring_motor_en !== 1'b0) begin
        fails++;
        $display("FAIL invalid_req[%0d]: got busy=%b error=%b motor=%b, want 0/1/0", k, upi_busy, error, spring_motor_en);
      end
    end
    upi_pay_req = 1'b0;
  endtask

  task automatic test_hold_amount();
    tray_sel = 3'd1; product_sel = 3'd2;
    step();
    upi_pay_req = 1'b1;
    step();  // E0
    upi_pay_req = 1'b0;
    tray_sel = 3'd4; product_sel = 3'd4;
    tests++;
    if (upi_success !== 1'b0 || upi_busy !== 1'b1) begin
      fails++;
      $display("FAIL hold_restart: got succ=%b busy=%b, want 0/1", upi_success, upi_busy);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (amount !== 8'd30 || error !== 1'b0) begin
        fails++;
        $display("FAIL hold_amount[%0d]: got amount=%0d error=%b, want 30/0", k, amount, error);
      end
    end
    wait_dispense("hold_dispense");
    tests++;
    if (amount !== 8'd30) begin
      fails++;
      $display("FAIL hold_amount_done: got amount=%0d, want 30", amount);
    end
    step();
    step();
    tests++;
    if (amount !== 8'd70 || error !== 1'b0) begin
      fails++;
      $display("FAIL hold_requote: got amount=%0d error=%b, want 70/0", amount, error);
    end
  endtask

  task automatic test_back_to_back();
    tray_sel = 3'd0; product_sel = 3'd1;
    step();
    upi_pay_req = 1'b1;  // held through the whole transaction
    step();
    wait_dispense("b2b_first");
    step();
    tests++;
    if (upi_busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: got busy=%b, want 0", upi_busy);
    end
    step();
    tests++;
    if (upi_busy !== 1'b1 || amount !== 8'd15) begin
      fails++;
      $display("FAIL b2b_retrigger: got busy=%b amount=%0d, want 1/15", upi_busy, amount);
    end
    upi_pay_req = 1'b0;
    wait_dispense("b2b_second");
    step();
    step();
  endtask

  task automatic test_timeout();
    tray_sel = 3'd2; product_sel = 3'd0;
    step();
    upi_pay_req_2 = 1'b1;
    step();  // E0
    upi_pay_req_2 = 1'b0;
    tests++;
    if (upi_busy_2 !== 1'b1 || amount_2 !== 8'd30) begin
      fails++;
      $display("FAIL to_accept: got busy=%b amount=%0d, want 1/30", upi_busy_2, amount_2);
    end
    for (int k = 1; k < 10; k++) begin
      step();
      tests++;
      if (error_2 !== 1'b0 || upi_busy_2 !== 1'b1) begin
        fails++;
        $display("FAIL to_wait[%0d]: got error=%b busy=%b, want 0/1", k, error_2, upi_busy_2);
      end
    end
    step();  // E0+10
    tests++;
    if (error_2 !== 1'b1 || upi_busy_2 !== 1'b0) begin
      fails++;
      $display("FAIL to_abort: got error=%b busy=%b, want 1/0", error_2, upi_busy_2);
    end
    step();
    tests++;
    if (error_2 !== 1'b0) begin
      fails++;
      $display("FAIL to_error_pulse: got error=%b, want 0", error_2);
    end
    for (int k = 0; k < 15; k++) begin
      step();
      tests++;
      if (spring_motor_en_2 !== 1'b0 || dispense_2 !== 1'b0 || upi_pay_done_2 !== 1'b0 || upi_success_2 !== 1'b0) begin
        fails++;
        $display("FAIL to_quiet[%0d]: got motor=%b disp=%b done=%b succ=%b, want all 0",
                 k, spring_motor_en_2, dispense_2, upi_pay_done_2, upi_success_2);
      end
    end
  endtask

  task automatic test_reset_vend();
    int n;
    tray_sel = 3'd3; product_sel = 3'd1;
    step();
    upi_pay_req = 1'b1;
    step();
    upi_pay_req = 1'b0;
    n = 0;
    while (spring_motor_en !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    tests++;
    if (spring_motor_en !== 1'b1) begin
      fails++;
      $display("FAIL rv_motor: motor never rose within 30 cycles");
    end
    step();
    rst = 1'b1;
    step();
    tests++;
    if ({spring_motor_en, dispense, amount, error, upi_pay_done, upi_busy, upi_success} !== 14'd0) begin
      fails++;
      $display("FAIL rv_reset: got motor=%b disp=%b amt=%0d err=%b done=%b busy=%b succ=%b, want all 0",
               spring_motor_en, dispense, amount, error, upi_pay_done, upi_busy, upi_success);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      tests++;
      if (dispense !== 1'b0 || spring_motor_en !== 1'b0) begin
        fails++;
        $display("FAIL rv_nodispense[%0d]: got disp=%b motor=%b, want 0/0", k, dispense, spring_motor_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_price();
    test_vend();
    test_invalid();
    test_hold_amount();
    test_back_to_back();
    test_timeout();
    test_reset_vend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
